// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and default timing.
// The optional watchdog in ps2_tx is enabled with the PS2_TX_TIMEOUT_EN macro.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        WAIT_REL
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    localparam int PS2_RTS_CYCLES     = 5000;
    localparam int PS2_FILTER_LEN     = 8;
    localparam int PS2_TIMEOUT_CYCLES = 750000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: level changes only after FILTER_LEN identical samples,
// fall_tick_o pulses for one cycle on each filtered 1->0 transition.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_i,
    output logic level_o,
    output logic fall_tick_o
);

    logic [FILTER_LEN-1:0] sr_q;
    logic                  level_q;
    logic                  level_d;
    logic                  tick_q;

    always_comb begin
        level_d = level_q;
        if (&sr_q)
            level_d = 1'b1;
        else if (~|sr_q)
            level_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '1;
            level_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sr_q    <= {ps2c_i, sr_q[FILTER_LEN-1:1]};
            level_q <= level_d;
            tick_q  <= level_q & ~level_d;
        end
    end

    assign level_o     = level_q;
    assign fall_tick_o = tick_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, LSB-first byte with odd parity,
// device acknowledge check. Define PS2_TX_TIMEOUT_EN to add a frame watchdog.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_tx_state_e    state_q;
    logic [8:0]       sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       n_q;
    logic             ok_q;
    logic             c_low_q;
    logic             d_low_q;
    logic             idle_q;
    logic             done_q;
    logic             err_q;
    logic             clk_level;
    logic             fall_tick;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .ps2c_i      (ps2c),
        .level_o     (clk_level),
        .fall_tick_o (fall_tick)
    );

    // Open-drain: the lines are only ever pulled low or released.
    assign ps2c = c_low_q ? 1'b0 : 1'bz;
    assign ps2d = d_low_q ? 1'b0 : 1'bz;

    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            ok_q    <= 1'b0;
            c_low_q <= 1'b0;
            d_low_q <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_ps2) begin
                        sr_q    <= {odd_parity(din), din};
                        cnt_q   <= '0;
                        c_low_q <= 1'b1;
                        idle_q  <= 1'b0;
                        state_q <= RTS;
                    end
                end
                RTS: begin
                    if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
                        c_low_q <= 1'b0;
                        d_low_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= START;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                START: begin
                    if (fall_tick) begin
                        d_low_q <= ~sr_q[0];
                        n_q     <= 4'd1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // n counts bits already presented; the ninth is parity.
                    if (fall_tick) begin
                        if (n_q == 4'd9) begin
                            d_low_q <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            sr_q    <= {1'b0, sr_q[8:1]};
                            d_low_q <= ~sr_q[1];
                            n_q     <= n_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (fall_tick) begin
                        ok_q    <= ~ps2d;
                        state_q <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (ps2d && clk_level) begin
                        done_q  <= ok_q;
                        err_q   <= ~ok_q;
                        idle_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides the per-state logic once the device goes quiet.
            if (state_q inside {START, DATA, STOP, WAIT_REL}) begin
                if (fall_tick) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    c_low_q <= 1'b0;
                    d_low_q <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b1;
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`endif
        end
    end

endmodule
